// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: shares the instruction memory port between a
// loader (while idle/halted) and a single-entry fetch stage feeding decode.
module instr_fetch_ctrl #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter logic [7:0] HALT_CODE  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ld_valid,
  input  logic [7:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       if_valid,
  output logic [7:0] if_instr,
  output logic [7:0] if_pc,
  input  logic       if_ready,
  input  logic       br_valid,
  input  logic [7:0] br_target,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_if_instr;
  logic [7:0] r_if_pc;
  logic       r_if_valid;
  logic       r_halted;

  logic       w_capture;
  logic       w_ld_ready;
  logic       w_mem_we;

  // The loader owns the memory port only outside FETCH, and never in the
  // cycle a start arrives, so a restart cannot race a write.
  assign w_ld_ready = (r_state != S_FETCH) & ~start;
  assign w_mem_we   = ld_valid & w_ld_ready;
  assign w_capture  = (~r_if_valid | if_ready) & ~br_valid;

  assign ld_ready  = w_ld_ready;
  assign mem_we    = w_mem_we;
  assign mem_wdata = ld_data;
  assign mem_addr  = w_mem_we ? ld_addr : r_pc;

  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;
  assign halted   = r_halted;

  // A redirect always wins over a capture, so a halt byte sitting at the
  // current pc is never taken when a branch arrives in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= START_ADDR;
      r_if_valid <= 1'b0;
      r_if_instr <= 8'h00;
      r_if_pc    <= 8'h00;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_halted   <= 1'b0;
            r_pc       <= START_ADDR;
            r_if_valid <= 1'b0;
          end else if (r_if_valid && if_ready) begin
            r_if_valid <= 1'b0;
          end
        end
        S_FETCH: begin
          if (br_valid) begin
            r_pc       <= br_target;
            r_if_valid <= 1'b0;
          end else if (w_capture) begin
            r_if_instr <= mem_rdata;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + 8'd1;
            if (mem_rdata == HALT_CODE) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed load/run/stall/branch/
// wrap/reset steps followed by random traffic against a program-image model.
module tb_instr_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ldValid;
  logic [7:0] ldAddr;
  logic [7:0] ldData;
  logic       ldReady;
  logic [7:0] memAddr;
  logic [7:0] memWdata;
  logic       memWe;
  logic [7:0] memRdata;
  logic       ifValid;
  logic [7:0] ifInstr;
  logic [7:0] ifPc;
  logic       ifReady;
  logic       brValid;
  logic [7:0] brTarget;
  logic       halted;

  logic       start2;
  logic       ifReady2;
  logic       ldReady2;
  logic [7:0] memAddr2;
  logic [7:0] memWdata2;
  logic       memWe2;
  logic [7:0] memRdata2;
  logic       ifValid2;
  logic [7:0] ifInstr2;
  logic [7:0] ifPc2;
  logic       halted2;

  logic       memClear;
  logic [7:0] mem [256];
  logic [7:0] image [256];
  logic [7:0] prog [7];

  int total = 0;
  int bad   = 0;

  // Model of what decode should see, kept in terms of the program image.
  bit         mRun;
  bit         mHalted;
  logic [7:0] mNext;
  bit         mValid;
  logic [7:0] mPc;
  logic [7:0] mInstr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (memWe) begin
      mem[memAddr] <= memWdata;
    end
  end
  assign memRdata  = mem[memAddr];
  assign memRdata2 = mem[memAddr2];

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ldValid), .ld_addr(ldAddr), .ld_data(ldData), .ld_ready(ldReady),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_we(memWe), .mem_rdata(memRdata),
    .if_valid(ifValid), .if_instr(ifInstr), .if_pc(ifPc), .if_ready(ifReady),
    .br_valid(brValid), .br_target(brTarget), .halted(halted)
  );

  instr_fetch_ctrl #(.START_ADDR(8'hFE), .HALT_CODE(8'hFF)) dutWrap (
    .clk(clk), .rst(rst), .start(start2),
    .ld_valid(1'b0), .ld_addr(8'h00), .ld_data(8'h00), .ld_ready(ldReady2),
    .mem_addr(memAddr2), .mem_wdata(memWdata2), .mem_we(memWe2), .mem_rdata(memRdata2),
    .if_valid(ifValid2), .if_instr(ifInstr2), .if_pc(ifPc2), .if_ready(ifReady2),
    .br_valid(1'b0), .br_target(8'h00), .halted(halted2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Random decode/redirect/restart pressure on the main instance.
  task automatic applyStimulus;
    ifReady  = ($urandom_range(0, 3) != 0);
    brValid  = ($urandom_range(0, 7) == 0);
    brTarget = 8'($urandom_range(0, 6));
    start    = ($urandom_range(0, 3) == 0);
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic modelStep;
    if (mRun) begin
      if (brValid) begin
        mNext  = brTarget;
        mValid = 1'b0;
      end else if (!mValid || ifReady) begin
        mPc    = mNext;
        mInstr = image[mNext];
        mValid = 1'b1;
        mNext  = mNext + 8'd1;
        if (mInstr == 8'hFF) begin
          mRun    = 1'b0;
          mHalted = 1'b1;
        end
      end
    end else if (start) begin
      mRun    = 1'b1;
      mHalted = 1'b0;
      mNext   = 8'h00;
      mValid  = 1'b0;
    end else if (mValid && ifReady) begin
      mValid = 1'b0;
    end
  endtask

  initial begin
    prog = '{8'h1b, 8'h73, 8'h4e, 8'hc5, 8'h0c, 8'h59, 8'hFF};
    for (int i = 0; i < 256; i++) image[i] = 8'h00;
    rst = 1'b1; memClear = 1'b1;
    start = 1'b0; ldValid = 1'b0; ldAddr = 8'h00; ldData = 8'h00;
    ifReady = 1'b0; brValid = 1'b0; brTarget = 8'h00;
    start2 = 1'b0; ifReady2 = 1'b0;
    tick; tick;
    checkOutput("rst_if_valid", {7'd0, ifValid}, 8'h00);
    checkOutput("rst_halted", {7'd0, halted}, 8'h00);
    checkOutput("rst_ld_ready", {7'd0, ldReady}, 8'h01);
    checkOutput("rst_mem_we", {7'd0, memWe}, 8'h00);
    checkOutput("rst_if_pc", ifPc, 8'h00);
    checkOutput("rst_if_instr", ifInstr, 8'h00);
    checkOutput("rst_mem_addr", memAddr, 8'h00);
    rst = 1'b0; memClear = 1'b0;
    tick;

    for (int i = 0; i < 7; i++) begin
      ldValid = 1'b1; ldAddr = 8'(i); ldData = prog[i];
      #1;
      checkOutput("load_ld_ready", {7'd0, ldReady}, 8'h01);
      checkOutput("load_mem_we", {7'd0, memWe}, 8'h01);
      checkOutput("load_mem_addr", memAddr, 8'(i));
      checkOutput("load_mem_wdata", memWdata, prog[i]);
      image[i] = prog[i];
      tick;
    end

    ldAddr = 8'h07; ldData = 8'hAA; start = 1'b1;
    #1;
    checkOutput("start_ld_ready", {7'd0, ldReady}, 8'h00);
    checkOutput("start_mem_we", {7'd0, memWe}, 8'h00);
    tick;
    start = 1'b0; ldValid = 1'b0;
    checkOutput("run_first_if_valid", {7'd0, ifValid}, 8'h00);
    checkOutput("run_fetch_ld_ready", {7'd0, ldReady}, 8'h00);
    checkOutput("run_mem7_untouched", mem[7], 8'h00);
    ifReady = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick;
      checkOutput("run_if_valid", {7'd0, ifValid}, 8'h01);
      checkOutput("run_if_instr", ifInstr, prog[k]);
      checkOutput("run_if_pc", ifPc, 8'(k));
      checkOutput("run_halted", {7'd0, halted}, (k == 6) ? 8'h01 : 8'h00);
    end
    tick;
    checkOutput("halt_consumed", {7'd0, ifValid}, 8'h00);
    checkOutput("halt_stays", {7'd0, halted}, 8'h01);

    start2 = 1'b1; tick; start2 = 1'b0; ifReady2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      checkOutput("wrap_if_pc", ifPc2, 8'(8'hFE + k));
      checkOutput("wrap_if_instr", ifInstr2, image[8'(8'hFE + k)]);
    end
    ifReady2 = 1'b0;

    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick;
    checkOutput("stall_pre_pc", ifPc, 8'h02);
    ifReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checkOutput("stall_if_instr", ifInstr, 8'h4e);
      checkOutput("stall_if_pc", ifPc, 8'h02);
      checkOutput("stall_pc", memAddr, 8'h03);
    end
    ifReady = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("stall_resume_instr", ifInstr, 8'hc5);
    checkOutput("stall_resume_pc", ifPc, 8'h03);
    for (int k = 0; k < 10 && !halted; k++) tick;
    checkOutput("stall_reach_halt", {7'd0, halted}, 8'h01);

    ifReady = 1'b0; brValid = 1'b1; brTarget = 8'h02;
    tick;
    checkOutput("halt_br_valid", {7'd0, ifValid}, 8'h01);
    checkOutput("halt_br_pc", ifPc, 8'h06);
    checkOutput("halt_br_halted", {7'd0, halted}, 8'h01);
    brValid = 1'b0; ifReady = 1'b1;
    tick;
    checkOutput("halt_clear", {7'd0, ifValid}, 8'h00);

    start = 1'b1; tick; start = 1'b0;
    tick; tick;
    checkOutput("br_pre_pc", ifPc, 8'h01);
    brValid = 1'b1; brTarget = 8'h04;
    tick;
    brValid = 1'b0;
    checkOutput("br_flush", {7'd0, ifValid}, 8'h00);
    tick;
    checkOutput("br_target_valid", {7'd0, ifValid}, 8'h01);
    checkOutput("br_target_instr", ifInstr, 8'h0c);
    checkOutput("br_target_pc", ifPc, 8'h04);
    for (int k = 0; k < 10 && !halted; k++) tick;
    tick;

    start = 1'b1; tick; start = 1'b0;
    brValid = 1'b1; brTarget = 8'h06;
    tick;
    brTarget = 8'h02;
    tick;
    checkOutput("prio_halted", {7'd0, halted}, 8'h00);
    checkOutput("prio_if_valid", {7'd0, ifValid}, 8'h00);
    brValid = 1'b0;
    tick;
    checkOutput("prio_instr", ifInstr, 8'h4e);
    checkOutput("prio_pc", ifPc, 8'h02);
    tick;
    checkOutput("midrst_pre_pc", ifPc, 8'h03);
    rst = 1'b1;
    #1;
    checkOutput("midrst_if_valid", {7'd0, ifValid}, 8'h00);
    checkOutput("midrst_ld_ready", {7'd0, ldReady}, 8'h01);
    checkOutput("midrst_halted", {7'd0, halted}, 8'h00);
    rst = 1'b0;
    tick;
    checkOutput("midrst_idle", {7'd0, ifValid}, 8'h00);
    checkOutput("midrst_idle_ld_ready", {7'd0, ldReady}, 8'h01);
    start = 1'b1; tick; start = 1'b0;
    tick;
    checkOutput("midrst_restart_instr", ifInstr, 8'h1b);
    checkOutput("midrst_restart_pc", ifPc, 8'h00);

    mRun = 1'b1; mHalted = 1'b0; mNext = 8'h01;
    mValid = 1'b1; mPc = 8'h00; mInstr = 8'h1b;
    for (int n = 0; n < 300; n++) begin
      applyStimulus;
      modelStep;
      tick;
      checkOutput("rand_if_valid", {7'd0, ifValid}, {7'd0, mValid});
      checkOutput("rand_halted", {7'd0, halted}, {7'd0, mHalted});
      if (mValid) begin
        checkOutput("rand_if_pc", ifPc, mPc);
        checkOutput("rand_if_instr", ifInstr, mInstr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
